// File: rtl/button_debounce_pulser_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// the default stability length and the counter width helper.
package button_debounce_pulser_pkg;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'b00,
      ST_PRESS_WAIT   = 2'b01,
      ST_PRESSED      = 2'b10,
      ST_RELEASE_WAIT = 2'b11
   } db_state_e;

   // Width needed to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_debounce_pulser_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into clk.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/button_debounce_pulser.sv
// Debounces a raw push-button and emits one-cycle press/release pulses;
// press_pulse is the toggle-enable of the downstream 4-bit counter.
module button_debounce_pulser
   import button_debounce_pulser_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned     CNT_W   = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s;
   db_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_level_q;
   logic             press_pulse_q;
   logic             release_pulse_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (s)
   );

   // A level change is accepted only after the first differing sample plus
   // STABLE_CYCLES further agreeing samples; any reversal drops back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         btn_level_q     <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
      end else begin
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s) begin
                  state_q <= ST_PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!s) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q       <= ST_PRESSED;
                  cnt_q         <= '0;
                  btn_level_q   <= 1'b1;
                  press_pulse_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!s) begin
                  state_q <= ST_RELEASE_WAIT;
                  cnt_q   <= '0;
               end
            end
            ST_RELEASE_WAIT: begin
               // Bouncing back high is a continuation of the same press.
               if (s) begin
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q         <= ST_IDLE;
                  cnt_q           <= '0;
                  btn_level_q     <= 1'b0;
                  release_pulse_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_level     = btn_level_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_button_debounce_pulser.sv
// Directed bench for button_debounce_pulser (STABLE_CYCLES=4) with an
// event scoreboard of expected pulse cycles and a model 4-bit counter.
module tb_button_debounce_pulser;

   localparam int S   = 4;
   localparam int LAT = S + 3;  // drive after edge N -> first sample at N+1 -> pulse after edge N+1+S+2

   typedef enum int {EV_PRESS, EV_RELEASE, EV_RESET} ev_kind_e;
   typedef struct {
      int       cyc;
      ev_kind_e kind;
   } ev_t;

   logic clk;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;

   int       checks   = 0;
   int       failures = 0;
   int       edge_n   = 0;
   bit       mon_en   = 1'b0;
   logic     exp_p;
   logic     exp_r;
   logic     exp_lvl  = 1'b0;
   logic [3:0] cnt4   = 4'h0;
   logic [3:0] cnt4_start;
   ev_t      sb[$];
   ev_t      ev;
   int       base;

   button_debounce_pulser #(.STABLE_CYCLES(S)) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int cyc, input ev_kind_e kind);
      ev_t e;
      e.cyc  = cyc;
      e.kind = kind;
      sb.push_back(e);
   endtask

   // Monitor: every cycle compare outputs against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_p = 1'b0;
         exp_r = 1'b0;
         while (sb.size() > 0 && sb[0].cyc < edge_n) begin
            check("event_missed", edge_n, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == edge_n) begin
            ev = sb.pop_front();
            case (ev.kind)
               EV_PRESS:   begin exp_p = 1'b1; exp_lvl = 1'b1; end
               EV_RELEASE: begin exp_r = 1'b1; exp_lvl = 1'b0; end
               default:    exp_lvl = 1'b0;
            endcase
         end
         check("press_pulse", {31'd0, press_pulse}, {31'd0, exp_p});
         check("release_pulse", {31'd0, release_pulse}, {31'd0, exp_r});
         check("btn_level", {31'd0, btn_level}, {31'd0, exp_lvl});
         if (press_pulse === 1'b1) cnt4 = cnt4 + 4'h1;
      end
   end

   initial begin
      rst    = 1'b1;
      btn_in = 1'b0;
      tick(2);
      rst    = 1'b0;
      mon_en = 1'b1;   // first monitored cycle checks the reset state
      tick(3);

      // Clean press held 20 cycles, then release held 12 cycles.
      base = edge_n; btn_in = 1'b1; push(base + LAT, EV_PRESS);
      tick(20);
      base = edge_n; btn_in = 1'b0; push(base + LAT, EV_RELEASE);
      tick(12);

      // Glitches of 1..4 cycles high, each followed by one low cycle.
      for (int w = 1; w <= 4; w++) begin
         btn_in = 1'b1; tick(w);
         btn_in = 1'b0; tick(1);
      end
      tick(10);

      // Press, 3-cycle release bounce, press continues, then real release.
      base = edge_n; btn_in = 1'b1; push(base + LAT, EV_PRESS);
      tick(10);
      btn_in = 1'b0; tick(3);
      btn_in = 1'b1; tick(10);
      base = edge_n; btn_in = 1'b0; push(base + LAT, EV_RELEASE);
      tick(12);

      // Reset while in PRESS_WAIT with cnt=2; button stays high through it.
      base = edge_n; btn_in = 1'b1;
      tick(5);
      rst = 1'b1; push(edge_n + 1, EV_RESET);
      tick(1);
      rst = 1'b0;
      base = edge_n; push(base + LAT, EV_PRESS);
      tick(12);
      base = edge_n; btn_in = 1'b0; push(base + LAT, EV_RELEASE);
      tick(12);

      // Ten full press/release cycles driving the model counter's enable.
      cnt4_start = cnt4;
      for (int i = 0; i < 10; i++) begin
         base = edge_n; btn_in = 1'b1; push(base + LAT, EV_PRESS);
         tick(10);
         base = edge_n; btn_in = 1'b0; push(base + LAT, EV_RELEASE);
         tick(10);
      end
      tick(2);
      check("counter_advance", {28'd0, 4'(cnt4 - cnt4_start)}, 32'hA);

      tick(5);
      check("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
